lif_neuron_array_tm: RTL and testbench

- Time-multiplexed, parametrised LIF neuron array; next generation of the parallel per-neuron LIF core.
- Neuron state (vmem, refractory count, input accumulator) lives in register arrays.
- Synaptic events are accumulated between timesteps; each `tick` triggers a one-neuron-per-cycle update sweep.
- Spike IDs stream out on a valid/ready port to the routing network.

---
 rtl/snn_lif_pkg.sv | 38 +++
 rtl/lif_update_unit.sv | 47 ++++
 rtl/lif_neuron_array_tm.sv | 188 ++++++++++++++++++
 tb/tb_lif_neuron_array_tm.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_lif_pkg.sv
// Shared types, constants and saturating arithmetic for the time-multiplexed LIF neuron array.
package snn_lif_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } lif_state_e;

    localparam logic RST_ZERO = 1'b0;
    localparam logic RST_SUB  = 1'b1;

    // 1.0 in 16.8 fixed point
    localparam logic [23:0] DEFAULT_THRESHOLD = 24'h000100;

    // Wide working width: operands are sign-extended into it, so the raw sum never overflows.
    localparam int SAT_W = 64;

    // Adds two sign-extended values and clamps the result to the signed range of `width` bits.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational single-neuron update: refractory countdown, leak, integrate, threshold and reset.
module lif_update_unit
    import snn_lif_pkg::*;
#(
    parameter int VMEM_W    = 24,
    parameter int REFRACT_W = 4,
    parameter int SHIFT_W   = 5
) (
    input  logic signed [VMEM_W-1:0] vmem,
    input  logic signed [VMEM_W-1:0] acc,
    input  logic [REFRACT_W-1:0]     refract,
    input  logic signed [VMEM_W-1:0] threshold,
    input  logic [SHIFT_W-1:0]       leak_shift,
    input  logic                     reset_mode,
    input  logic [REFRACT_W-1:0]     refract_cfg,
    output logic signed [VMEM_W-1:0] vmem_nxt,
    output logic [REFRACT_W-1:0]     refract_nxt,
    output logic                     spike
);

    logic signed [VMEM_W-1:0] leak;
    logic signed [VMEM_W-1:0] v_leak;
    logic signed [VMEM_W-1:0] v_int;
    logic signed [VMEM_W-1:0] v_sub;

    // Leak never overflows: the shifted term has the same sign and no larger magnitude than vmem.
    assign leak   = (leak_shift != '0) ? (vmem >>> leak_shift) : '0;
    assign v_leak = vmem - leak;
    assign v_int  = VMEM_W'(sat_add(SAT_W'(v_leak), SAT_W'(acc), VMEM_W));
    assign v_sub  = VMEM_W'(sat_add(SAT_W'(v_int), -SAT_W'(threshold), VMEM_W));

    // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        spike       = 1'b0;
        vmem_nxt    = v_int;
        refract_nxt = refract;
        if (refract != '0) begin
            refract_nxt = refract - REFRACT_W'(1);
            vmem_nxt    = '0;
        end else if (v_int >= threshold) begin
            spike       = 1'b1;
            refract_nxt = refract_cfg;
            vmem_nxt    = (reset_mode == RST_SUB) ? v_sub : '0;
        end
    end

endmodule

// File: rtl/lif_neuron_array_tm.sv
// Time-multiplexed LIF neuron array: events accumulate while idle, each tick sweeps one neuron per cycle.
// Optional spike statistics outputs are built when LIF_SPIKE_STATS_EN is defined.
module lif_neuron_array_tm
    import snn_lif_pkg::*;
#(
    parameter int NUM_NEURONS = 256,
    parameter int VMEM_W      = 24,
    parameter int ID_W        = $clog2(NUM_NEURONS),
    parameter int REFRACT_W   = 4,
    parameter int SHIFT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_enable,
    input  logic [VMEM_W-1:0]    cfg_threshold,
    input  logic [SHIFT_W-1:0]   cfg_leak_shift,
    input  logic                 cfg_reset_mode,
    input  logic [REFRACT_W-1:0] cfg_refract,
    input  logic                 tick,
    input  logic                 ev_valid,
    output logic                 ev_ready,
    input  logic [ID_W-1:0]      ev_id,
    input  logic [VMEM_W-1:0]    ev_weight,
    output logic                 spk_valid,
    input  logic                 spk_ready,
    output logic [ID_W-1:0]      spk_id,
    output logic                 busy,
    output logic                 done,
`ifdef LIF_SPIKE_STATS_EN
    output logic [ID_W:0]        stat_sweep_spikes,
    output logic [31:0]          stat_total_spikes,
`endif
    output logic                 err_drop
);

    localparam int              IDX_W    = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic signed [VMEM_W-1:0] vmem_q    [NUM_NEURONS];
    logic signed [VMEM_W-1:0] acc_q     [NUM_NEURONS];
    logic [REFRACT_W-1:0]     refract_q [NUM_NEURONS];

    lif_state_e       state_q;
    lif_state_e       state_d;
    logic [IDX_W-1:0] ptr_q;
    logic             spk_valid_q;
    logic [ID_W-1:0]  spk_id_q;
    logic             done_q;
    logic             err_q;

    logic signed [VMEM_W-1:0] thr_s;
    logic signed [VMEM_W-1:0] weight_s;
    logic signed [VMEM_W-1:0] acc_ev_sum;
    logic [IDX_W-1:0]         ev_idx;
    logic                     ev_in_range;
    logic                     ev_fire;
    logic                     ptr_last;
    logic                     sweep_adv;

    logic signed [VMEM_W-1:0] upd_vmem;
    logic [REFRACT_W-1:0]     upd_refract;
    logic                     upd_spike;

    assign thr_s    = cfg_threshold;
    assign weight_s = ev_weight;

    // One extra bit so NUM_NEURONS itself is representable when it is a power of two.
    assign ev_in_range = ({1'b0, ev_id} < (ID_W + 1)'(NUM_NEURONS));
    assign ev_idx      = ev_id[IDX_W-1:0];
    assign ev_fire     = ev_valid && ev_ready;
    assign acc_ev_sum  = VMEM_W'(sat_add(SAT_W'(acc_q[ev_idx]), SAT_W'(weight_s), VMEM_W));

    // A pending spike the receiver has not taken freezes the sweep so no spike is overwritten.
    assign ptr_last  = (ptr_q == LAST_IDX);
    assign sweep_adv = (state_q == SWEEP) && !(spk_valid_q && !spk_ready);

    lif_update_unit #(
        .VMEM_W    (VMEM_W),
        .REFRACT_W (REFRACT_W),
        .SHIFT_W   (SHIFT_W)
    ) u_update (
        .vmem        (vmem_q[ptr_q]),
        .acc         (acc_q[ptr_q]),
        .refract     (refract_q[ptr_q]),
        .threshold   (thr_s),
        .leak_shift  (cfg_leak_shift),
        .reset_mode  (cfg_reset_mode),
        .refract_cfg (cfg_refract),
        .vmem_nxt    (upd_vmem),
        .refract_nxt (upd_refract),
        .spike       (upd_spike)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick && cfg_enable) state_d = SWEEP;
            SWEEP:   if (sweep_adv && ptr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A tick in the same cycle as an event takes priority; the event waits for the next idle cycle.
    always_comb begin
        ev_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE:    ev_ready = rst_n && cfg_enable && !tick;
            SWEEP:   busy     = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the neuron state arrays are flip-flops rather than a RAM, so reset clears every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                vmem_q[i]    <= '0;
                acc_q[i]     <= '0;
                refract_q[i] <= '0;
            end
            ptr_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_id_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= (ev_fire && !ev_in_range) || ((state_q == SWEEP) && tick);

            if (ev_fire && ev_in_range) begin
                acc_q[ev_idx] <= acc_ev_sum;
            end

            if (sweep_adv) begin
                vmem_q[ptr_q]    <= upd_vmem;
                acc_q[ptr_q]     <= '0;
                refract_q[ptr_q] <= upd_refract;
                ptr_q            <= ptr_last ? '0 : ptr_q + IDX_W'(1);
                done_q           <= ptr_last;
            end

            if (sweep_adv && upd_spike) begin
                spk_valid_q <= 1'b1;
                spk_id_q    <= ID_W'(ptr_q);
            end else if (spk_ready) begin
                spk_valid_q <= 1'b0;
            end
        end
    end

    assign spk_valid = spk_valid_q;
    assign spk_id    = spk_id_q;
    assign done      = done_q;
    assign err_drop  = err_q;

`ifdef LIF_SPIKE_STATS_EN
    logic [ID_W:0] sweep_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep_cnt_q       <= '0;
            stat_sweep_spikes <= '0;
            stat_total_spikes <= '0;
        end else if (sweep_adv) begin
            if (ptr_last) begin
                stat_sweep_spikes <= sweep_cnt_q + (ID_W + 1)'(upd_spike);
                sweep_cnt_q       <= '0;
            end else if (upd_spike) begin
                sweep_cnt_q <= sweep_cnt_q + (ID_W + 1)'(1);
            end
            if (upd_spike && (stat_total_spikes != '1)) begin
                stat_total_spikes <= stat_total_spikes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lif_neuron_array_tm.sv
// Scoreboard bench for lif_neuron_array_tm: stimulus pushes expected spike ids, a monitor pops on handshake.
module tb_lif_neuron_array_tm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable;
    logic [23:0] cfg_threshold;
    logic [4:0]  cfg_leak_shift;
    logic        cfg_reset_mode;
    logic [3:0]  cfg_refract;
    logic        tick;
    logic        ev_valid;
    logic        ev_ready;
    logic [8:0]  ev_id;
    logic [23:0] ev_weight;
    logic        spk_valid;
    logic        spk_ready;
    logic [8:0]  spk_id;
    logic        busy;
    logic        done;
    logic        err_drop;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    // ID_W widened by one bit so an index equal to NUM_NEURONS can be presented.
    lif_neuron_array_tm #(
        .NUM_NEURONS (256),
        .VMEM_W      (24),
        .ID_W        (9),
        .REFRACT_W   (4),
        .SHIFT_W     (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_enable     (cfg_enable),
        .cfg_threshold  (cfg_threshold),
        .cfg_leak_shift (cfg_leak_shift),
        .cfg_reset_mode (cfg_reset_mode),
        .cfg_refract    (cfg_refract),
        .tick           (tick),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_id          (ev_id),
        .ev_weight      (ev_weight),
        .spk_valid      (spk_valid),
        .spk_ready      (spk_ready),
        .spk_id         (spk_id),
        .busy           (busy),
        .done           (done),
        .err_drop       (err_drop)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted spike is compared against the oldest expected id.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && spk_valid && spk_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spk_unexpected: got id %0d expected none", spk_id);
                end else begin
                    check("spk_id", 64'(spk_id), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ev_valid = 1'b0;
        tick     = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input logic [23:0] thr, input logic [4:0] shift,
                           input logic mode, input logic [3:0] refr);
        cfg_threshold  = thr;
        cfg_leak_shift = shift;
        cfg_reset_mode = mode;
        cfg_refract    = refr;
    endtask

    task automatic send_ev(input int id, input logic [23:0] w);
        bit ok = 1'b0;
        ev_valid  = 1'b1;
        ev_id     = 9'(id);
        ev_weight = w;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1;
            if (ev_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        ev_valid = 1'b0;
        check("ev_handshake", 64'(ok), 64'd1);
    endtask

    // Ticks once and counts edges until done; optionally re-ticks mid-sweep or toggles spk_ready.
    task automatic run_sweep(input int retick_at, input bit toggle, output int n);
        bit got = 1'b0;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        n    = 0;
        if (toggle) spk_ready = 1'b1;
        while (!got && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (toggle) spk_ready = ((n + 1) % 2 == 1);
            tick = (n == retick_at);
            if (retick_at > 0 && n == retick_at + 1) check("err_drop_retick", 64'(err_drop), 64'd1);
            if (done) got = 1'b1;
        end
        tick      = 1'b0;
        spk_ready = 1'b1;
        check("sweep_done_seen", 64'(got), 64'd1);
    endtask

    task automatic settle();
        repeat (3) cycle();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        bit flag;
        logic [23:0] leak_exp [3];
        leak_exp[0] = 24'h000078;
        leak_exp[1] = 24'h00003C;
        leak_exp[2] = 24'h00001E;

        rst_n = 1'b0; tick = 1'b0; ev_valid = 1'b0; ev_id = '0; ev_weight = '0;
        spk_ready = 1'b1; cfg_enable = 1'b1;
        set_cfg(24'h000100, 5'd0, 1'b0, 4'd2);
        cycle();
        cycle();
        check("rst_ev_ready", 64'(ev_ready), 64'd0);
        check("rst_spk_valid", 64'(spk_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err_drop", 64'(err_drop), 64'd0);
        check("rst_spk_id", 64'(spk_id), 64'd0);
        rst_n = 1'b1;

        // Single event, reset-to-zero
        send_ev(5, 24'h000180);
        exp_q.push_back(5);
        run_sweep(0, 1'b0, n);
        check("single_latency", 64'(n), 64'd256);
        settle();
        check("single_vmem5", 64'($unsigned(dut.vmem_q[5])), 64'h0);
        check("single_refract5", 64'(dut.refract_q[5]), 64'd2);
        check("single_acc5", 64'($unsigned(dut.acc_q[5])), 64'h0);

        // Refractory: timesteps 2 and 3 silent, timestep 4 spikes again
        for (int ts = 2; ts <= 4; ts++) begin
            send_ev(5, 24'h000180);
            if (ts == 4) exp_q.push_back(5);
            run_sweep(0, 1'b0, n);
            settle();
            check("refract_count", 64'(dut.refract_q[5]), (ts == 2) ? 64'd1 : (ts == 3) ? 64'd0 : 64'd2);
        end

        // Subtract-threshold reset
        do_reset();
        set_cfg(24'h000100, 5'd0, 1'b1, 4'd2);
        send_ev(5, 24'h000180);
        exp_q.push_back(5);
        run_sweep(0, 1'b0, n);
        settle();
        check("sub_vmem5", 64'($unsigned(dut.vmem_q[5])), 64'h080);

        // Leak with shift 1
        do_reset();
        set_cfg(24'h000100, 5'd1, 1'b0, 4'd0);
        send_ev(5, 24'h0000F0);
        run_sweep(0, 1'b0, n);
        check("leak_start", 64'($unsigned(dut.vmem_q[5])), 64'h0F0);
        for (int t = 0; t < 3; t++) begin
            run_sweep(0, 1'b0, n);
            settle();
            check("leak_vmem5", 64'($unsigned(dut.vmem_q[5])), 64'(leak_exp[t]));
        end

        // Accumulator saturation in both directions
        do_reset();
        set_cfg(24'h000100, 5'd0, 1'b0, 4'd0);
        send_ev(0, 24'h7FFFFF);
        send_ev(0, 24'h7FFFFF);
        check("sat_pos_acc0", 64'($unsigned(dut.acc_q[0])), 64'h7FFFFF);
        send_ev(1, 24'h800000);
        send_ev(1, 24'h800000);
        send_ev(1, 24'hFFFFFF);
        check("sat_neg_acc1", 64'($unsigned(dut.acc_q[1])), 64'h800000);

        // Backpressure: every neuron spikes, spk_ready alternates
        do_reset();
        set_cfg(24'h000100, 5'd0, 1'b0, 4'd0);
        for (int i = 0; i < 256; i++) begin
            send_ev(i, 24'h000180);
            exp_q.push_back(i);
        end
        run_sweep(0, 1'b1, n);
        check("bp_latency", 64'(n), 64'd511);
        settle();

        // Tick during sweep is dropped, no second sweep follows
        do_reset();
        send_ev(9, 24'h000180);
        exp_q.push_back(9);
        run_sweep(10, 1'b0, n);
        check("retick_latency", 64'(n), 64'd256);
        settle();
        flag = 1'b0;
        repeat (5) begin
            cycle();
            flag |= busy;
        end
        check("retick_no_second_sweep", 64'(flag), 64'd0);

        // Out-of-range event id
        do_reset();
        send_ev(256, 24'h000100);
        check("oor_err_drop", 64'(err_drop), 64'd1);
        flag = 1'b1;
        for (int i = 0; i < 256; i++) if (dut.acc_q[i] != '0) flag = 1'b0;
        check("oor_no_state_change", 64'(flag), 64'd1);
        cycle();
        check("oor_err_pulse_width", 64'(err_drop), 64'd0);

        // Tick and event in the same cycle: tick wins, event is taken after the sweep
        do_reset();
        ev_valid  = 1'b1;
        ev_id     = 9'd7;
        ev_weight = 24'h000010;
        tick      = 1'b1;
        #1;
        check("tick_wins_ev_ready", 64'(ev_ready), 64'd0);
        run_sweep(0, 1'b0, n);
        check("tick_ev_latency", 64'(n), 64'd256);
        #1;
        check("late_ev_ready", 64'(ev_ready), 64'd1);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        check("late_ev_acc7", 64'($unsigned(dut.acc_q[7])), 64'h10);

        // Reset mid-sweep with a stalled spike pending
        do_reset();
        send_ev(3, 24'h000180);
        spk_ready = 1'b0;
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        repeat (10) cycle();
        check("stall_spk_valid", 64'(spk_valid), 64'd1);
        check("stall_spk_id", 64'(spk_id), 64'd3);
        rst_n = 1'b0;
        cycle();
        check("midrst_spk_valid", 64'(spk_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        flag = 1'b1;
        for (int i = 0; i < 256; i++)
            if (dut.vmem_q[i] != '0 || dut.acc_q[i] != '0 || dut.refract_q[i] != '0) flag = 1'b0;
        check("midrst_arrays_clear", 64'(flag), 64'd1);
        rst_n = 1'b1;
        spk_ready = 1'b1;
        flag = 1'b0;
        repeat (300) begin
            cycle();
            flag |= done;
        end
        check("midrst_no_done", 64'(flag), 64'd0);
        check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
